// File: rtl/tl_ul_sram_responder_if.sv
// rtl/tl_ul_sram_responder_if.sv - TileLink-UL A/D channel bundle for the SRAM responder
interface tl_ul_sram_responder_if #(
    parameter int ADDR_W   = 15,
    parameter int SOURCE_W = 7
);
    logic                a_valid;
    logic                a_ready;
    logic [2:0]          a_opcode;
    logic [2:0]          a_param;
    logic [2:0]          a_size;
    logic [SOURCE_W-1:0] a_source;
    logic [ADDR_W-1:0]   a_address;
    logic [3:0]          a_mask;
    logic [31:0]         a_data;

    logic                d_valid;
    logic                d_ready;
    logic [2:0]          d_opcode;
    logic [2:0]          d_size;
    logic [SOURCE_W-1:0] d_source;
    logic                d_denied;
    logic                d_corrupt;
    logic [31:0]         d_data;

    modport master (
        output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, d_ready,
        input  a_ready, d_valid, d_opcode, d_size, d_source, d_denied, d_corrupt, d_data
    );

    modport slave (
        input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, d_ready,
        output a_ready, d_valid, d_opcode, d_size, d_source, d_denied, d_corrupt, d_data
    );
endinterface

// File: rtl/tl_ul_sram_responder.sv
// rtl/tl_ul_sram_responder.sv - TileLink-UL single-beat responder backed by a flop word array
module tl_ul_sram_responder #(
    parameter int DEPTH_LOG2 = 8,
    parameter int ADDR_W     = 15,
    parameter int SOURCE_W   = 7
) (
    input  logic                       clock,
    input  logic                       reset_n,
    tl_ul_sram_responder_if.slave      bus
);
    localparam int HI_LSB = DEPTH_LOG2 + 2;

    logic [31:0]         r_mem [2**DEPTH_LOG2];

    logic                r_d_valid;
    logic [2:0]          r_d_opcode;
    logic [2:0]          r_d_size;
    logic [SOURCE_W-1:0] r_d_source;
    logic                r_d_denied;
    logic                r_d_corrupt;
    logic [31:0]         r_d_data;

    logic                  w_a_ready;
    logic                  w_a_fire;
    logic [ADDR_W-1:0]     w_addr_hi;
    logic [DEPTH_LOG2-1:0] w_idx;
    logic                  w_is_get;
    logic                  w_is_put;
    logic                  w_oob;
    logic                  w_bad_size;
    logic                  w_misaligned;
    logic                  w_denied;
    logic                  w_wr;
    logic                  w_unused;

    // Accept whenever the D register is empty or being drained this cycle.
    assign w_a_ready = !r_d_valid || bus.d_ready;
    assign w_a_fire  = bus.a_valid && w_a_ready;

    assign w_addr_hi    = bus.a_address >> HI_LSB;
    assign w_idx        = bus.a_address[DEPTH_LOG2+1:2];
    assign w_is_get     = (bus.a_opcode == 3'd4);
    assign w_is_put     = (bus.a_opcode == 3'd0) || (bus.a_opcode == 3'd1);
    assign w_oob        = |w_addr_hi;
    assign w_bad_size   = (bus.a_size > 3'd2);
    assign w_misaligned = ((bus.a_size == 3'd1) && bus.a_address[0]) ||
                          ((bus.a_size == 3'd2) && (|bus.a_address[1:0]));
    assign w_denied     = w_oob || w_bad_size || w_misaligned || !(w_is_get || w_is_put);
    assign w_wr         = w_a_fire && w_is_put && !w_denied;
    assign w_unused     = &{1'b0, bus.a_param};

    // Array is deliberately outside the reset domain so contents survive reset.
    always_ff @(posedge clock) begin
        if (w_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.a_mask[i]) begin
                    r_mem[w_idx][8*i +: 8] <= bus.a_data[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_d_valid   <= 1'b0;
            r_d_opcode  <= 3'd0;
            r_d_size    <= 3'd0;
            r_d_source  <= '0;
            r_d_denied  <= 1'b0;
            r_d_corrupt <= 1'b0;
            r_d_data    <= 32'd0;
        end else if (w_a_fire) begin
            r_d_valid   <= 1'b1;
            r_d_opcode  <= w_is_get ? 3'd1 : 3'd0;
            r_d_size    <= bus.a_size;
            r_d_source  <= bus.a_source;
            r_d_denied  <= w_denied;
            r_d_corrupt <= w_is_get && w_denied;
            r_d_data    <= (w_is_get && !w_denied) ? r_mem[w_idx] : 32'd0;
        end else if (r_d_valid && bus.d_ready) begin
            r_d_valid   <= 1'b0;
        end
    end

    assign bus.a_ready   = w_a_ready;
    assign bus.d_valid   = r_d_valid;
    assign bus.d_opcode  = r_d_opcode;
    assign bus.d_size    = r_d_size;
    assign bus.d_source  = r_d_source;
    assign bus.d_denied  = r_d_denied;
    assign bus.d_corrupt = r_d_corrupt;
    assign bus.d_data    = r_d_data;
endmodule

// File: tb/tb_tl_ul_sram_responder.sv
// tb/tb_tl_ul_sram_responder.sv - directed vector bench for tl_ul_sram_responder
module tb_tl_ul_sram_responder;
    localparam int DEPTH_LOG2 = 8;
    localparam int ADDR_W     = 15;
    localparam int SOURCE_W   = 7;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    int   n_cmp   = 0;
    int   n_bad   = 0;
    int   n_fire  = 0;

    tl_ul_sram_responder_if #(.ADDR_W(ADDR_W), .SOURCE_W(SOURCE_W)) bus_if ();

    tl_ul_sram_responder #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .ADDR_W     (ADDR_W),
        .SOURCE_W   (SOURCE_W)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus_if)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (bus_if.a_valid && bus_if.a_ready) n_fire++;
    end

    typedef struct {
        logic [2:0]  op;
        logic [2:0]  size;
        logic [6:0]  src;
        logic [14:0] addr;
        logic [3:0]  mask;
        logic [31:0] data;
        logic [2:0]  e_op;
        logic        e_den;
        logic        e_cor;
        logic [31:0] e_data;
    } vec_t;

    vec_t vecs[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic drive_a(input logic [2:0] op, input logic [2:0] size, input logic [6:0] src,
                           input logic [14:0] addr, input logic [3:0] mask, input logic [31:0] data);
        bus_if.a_valid   = 1'b1;
        bus_if.a_opcode  = op;
        bus_if.a_size    = size;
        bus_if.a_source  = src;
        bus_if.a_address = addr;
        bus_if.a_mask    = mask;
        bus_if.a_data    = data;
    endtask

    task automatic chk_resp(input string tag, input logic [2:0] op, input logic [6:0] src,
                            input logic den, input logic [31:0] data);
        chk({tag, ".valid"},  32'(bus_if.d_valid),  32'd1);
        chk({tag, ".opcode"}, 32'(bus_if.d_opcode), 32'(op));
        chk({tag, ".source"}, 32'(bus_if.d_source), 32'(src));
        chk({tag, ".denied"}, 32'(bus_if.d_denied), 32'(den));
        chk({tag, ".data"},   32'(bus_if.d_data),   data);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int f0;
        // op size src addr mask data | e_op e_den e_cor e_data
        vecs[0]  = '{3'd0, 3'd2, 7'd5,  15'h010,  4'hF, 32'hDEADBEEF, 3'd0, 1'b0, 1'b0, 32'h0};
        vecs[1]  = '{3'd4, 3'd2, 7'd6,  15'h010,  4'hF, 32'h0,        3'd1, 1'b0, 1'b0, 32'hDEADBEEF};
        vecs[2]  = '{3'd1, 3'd2, 7'd1,  15'h010,  4'h6, 32'h11223344, 3'd0, 1'b0, 1'b0, 32'h0};
        vecs[3]  = '{3'd4, 3'd2, 7'd2,  15'h010,  4'h0, 32'h0,        3'd1, 1'b0, 1'b0, 32'hDE2233EF};
        vecs[4]  = '{3'd4, 3'd2, 7'd3,  15'h400,  4'hF, 32'h0,        3'd1, 1'b1, 1'b1, 32'h0};
        vecs[5]  = '{3'd0, 3'd2, 7'd4,  15'h012,  4'hF, 32'h12345678, 3'd0, 1'b1, 1'b0, 32'h0};
        vecs[6]  = '{3'd4, 3'd2, 7'd7,  15'h010,  4'hF, 32'h0,        3'd1, 1'b0, 1'b0, 32'hDE2233EF};
        vecs[7]  = '{3'd2, 3'd2, 7'd8,  15'h010,  4'hF, 32'h55555555, 3'd0, 1'b1, 1'b0, 32'h0};
        vecs[8]  = '{3'd4, 3'd3, 7'd9,  15'h010,  4'hF, 32'h0,        3'd1, 1'b1, 1'b1, 32'h0};
        vecs[9]  = '{3'd4, 3'd1, 7'd10, 15'h011,  4'hF, 32'h0,        3'd1, 1'b1, 1'b1, 32'h0};
        vecs[10] = '{3'd4, 3'd1, 7'd11, 15'h012,  4'hC, 32'h0,        3'd1, 1'b0, 1'b0, 32'hDE2233EF};
        vecs[11] = '{3'd0, 3'd2, 7'd12, 15'h3FC,  4'hF, 32'hCAFEF00D, 3'd0, 1'b0, 1'b0, 32'h0};
        vecs[12] = '{3'd4, 3'd2, 7'd13, 15'h3FC,  4'hF, 32'h0,        3'd1, 1'b0, 1'b0, 32'hCAFEF00D};
        vecs[13] = '{3'd4, 3'd2, 7'd14, 15'h7FFC, 4'hF, 32'h0,        3'd1, 1'b1, 1'b1, 32'h0};
        vecs[14] = '{3'd7, 3'd2, 7'd15, 15'h010,  4'hF, 32'h0,        3'd0, 1'b1, 1'b0, 32'h0};
        vecs[15] = '{3'd1, 3'd2, 7'd16, 15'h3FC,  4'h0, 32'h01020304, 3'd0, 1'b0, 1'b0, 32'h0};
        vecs[16] = '{3'd4, 3'd2, 7'd17, 15'h3FC,  4'hF, 32'h0,        3'd1, 1'b0, 1'b0, 32'hCAFEF00D};

        bus_if.a_valid = 1'b0; bus_if.a_opcode = 3'd0; bus_if.a_param = 3'd0; bus_if.a_size = 3'd0;
        bus_if.a_source = '0; bus_if.a_address = '0; bus_if.a_mask = 4'h0; bus_if.a_data = 32'h0;
        bus_if.d_ready = 1'b1;

        repeat (3) @(posedge clock);
        #1;
        chk("rst.d_valid",  32'(bus_if.d_valid),  32'd0);
        chk("rst.d_opcode", 32'(bus_if.d_opcode), 32'd0);
        chk("rst.d_source", 32'(bus_if.d_source), 32'd0);
        chk("rst.d_data",   bus_if.d_data,        32'd0);
        chk("rst.a_ready",  32'(bus_if.a_ready),  32'd1);
        @(negedge clock);
        reset_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            @(negedge clock);
            drive_a(vecs[i].op, vecs[i].size, vecs[i].src, vecs[i].addr, vecs[i].mask, vecs[i].data);
            @(posedge clock);
            #1;
            bus_if.a_valid = 1'b0;
            chk_resp($sformatf("v%0d", i), vecs[i].e_op, vecs[i].src, vecs[i].e_den, vecs[i].e_data);
            chk($sformatf("v%0d.corrupt", i), 32'(bus_if.d_corrupt), 32'(vecs[i].e_cor));
            chk($sformatf("v%0d.size", i),    32'(bus_if.d_size),    32'(vecs[i].size));
        end
        @(posedge clock);
        #1;
        chk("drain.d_valid", 32'(bus_if.d_valid), 32'd0);

        // Backpressure: one fire, then stall four cycles with fields frozen
        @(negedge clock);
        bus_if.d_ready = 1'b0;
        drive_a(3'd4, 3'd2, 7'd9, 15'h010, 4'hF, 32'h0);
        f0 = n_fire;
        @(posedge clock);
        #1;
        bus_if.a_source = 7'd10;
        for (int k = 0; k < 4; k++) begin
            @(posedge clock);
            #1;
            chk($sformatf("bp%0d.a_ready", k), 32'(bus_if.a_ready), 32'd0);
            chk_resp($sformatf("bp%0d", k), 3'd1, 7'd9, 1'b0, 32'hDE2233EF);
        end
        chk("bp.fires", 32'(n_fire - f0), 32'd1);
        @(negedge clock);
        bus_if.d_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clock);
            #1;
            chk_resp($sformatf("b2b%0d", k), 3'd1, 7'(10 + k), 1'b0, 32'hDE2233EF);
            bus_if.a_source = 7'(11 + k);
        end
        bus_if.a_valid = 1'b0;
        chk("b2b.fires", 32'(n_fire - f0), 32'd4);
        @(posedge clock);
        #1;
        chk("b2b.drain", 32'(bus_if.d_valid), 32'd0);

        // Streaming read-after-write with no bubble
        @(negedge clock);
        drive_a(3'd0, 3'd2, 7'd20, 15'h020, 4'hF, 32'hA5A5A5A5);
        @(posedge clock);
        #1;
        chk_resp("raw.put", 3'd0, 7'd20, 1'b0, 32'h0);
        drive_a(3'd4, 3'd2, 7'd21, 15'h020, 4'hF, 32'h0);
        @(posedge clock);
        #1;
        bus_if.a_valid = 1'b0;
        chk_resp("raw.get", 3'd1, 7'd21, 1'b0, 32'hA5A5A5A5);

        // Reset while a response is stalled
        @(negedge clock);
        bus_if.d_ready = 1'b0;
        drive_a(3'd4, 3'd2, 7'd3, 15'h020, 4'hF, 32'h0);
        @(posedge clock);
        #1;
        bus_if.a_valid = 1'b0;
        chk("mid.pending", 32'(bus_if.d_valid), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid.async_drop", 32'(bus_if.d_valid), 32'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(posedge clock);
            #1;
            chk($sformatf("mid.stale%0d", k), 32'(bus_if.d_valid), 32'd0);
        end
        @(negedge clock);
        bus_if.d_ready = 1'b1;
        drive_a(3'd4, 3'd2, 7'd30, 15'h020, 4'hF, 32'h0);
        @(posedge clock);
        #1;
        chk_resp("mid.keep20", 3'd1, 7'd30, 1'b0, 32'hA5A5A5A5);
        drive_a(3'd4, 3'd2, 7'd31, 15'h010, 4'hF, 32'h0);
        @(posedge clock);
        #1;
        bus_if.a_valid = 1'b0;
        chk_resp("mid.keep10", 3'd1, 7'd31, 1'b0, 32'hDE2233EF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
